twos_to_signmag_serial: RTL
===========================

# twos_to_signmag_serial

Serial decoder that converts a WIDTH-bit two's-complement word back into sign-magnitude form. It is the return path for the team's two's-complement generator. It processes one bit per clock, LSB first, using the copy-until-first-one-then-invert rule, so that negative operands are recovered as magnitudes without a full-width adder. It sits between a producer of signed words and any consumer that needs sign and magnitude separately, with valid/ready handshakes on both sides.

## Interface
Parameters:
- WIDTH, 4, word width in bits (>= 2)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word (high only in IDLE)
- in_data  input  WIDTH  two's-complement operand
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts the result
- out_sign  output  1  sign of the operand (in_data[WIDTH-1])
- out_mag  output  WIDTH  magnitude |in_data|
- out_minneg  output  1  operand was the most negative value, 1 followed by WIDTH-1 zeros

## Operation
- Reset is asynchronous on the falling edge of rst_n:
  - state = IDLE, in_ready = 1
  - out_valid = 0, out_sign = 0, out_mag = 0, out_minneg = 0
  - internal shift register, bit counter and seen_one flag all cleared
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - When in_valid && in_ready at a clock edge: latch in_data into the shift register, latch out_sign = in_data[WIDTH-1], clear seen_one, counter = 0, go to SHIFT.
- SHIFT: each cycle, take the shift-register LSB b.
  - If out_sign = 0, the result bit is b.
  - If out_sign = 1 and seen_one = 0, the result bit is b; set seen_one if b = 1.
  - If out_sign = 1 and seen_one = 1, the result bit is ~b.
  - The result bit shifts into the MSB of the magnitude register (LSB-first assembly). The counter increments.
  - After WIDTH bits: go to DONE, drive out_mag from the assembled register, set out_valid = 1.
  - out_minneg = out_sign & (out_mag == 1 followed by WIDTH-1 zeros).
- DONE:
  - out_valid = 1; out_sign, out_mag and out_minneg are held stable until out_valid && out_ready.
  - On that handshake: out_valid = 0, go to IDLE. Result registers keep their last value.
- in_data and in_valid are ignored outside IDLE. There is no input buffering.
- Width rules:
  - out_mag is WIDTH bits, so the most negative value's magnitude is representable.
  - Zero input gives out_sign = 0, out_mag = 0.
  - Negative zero cannot occur.

## Timing
- Accept at edge N. SHIFT runs on edges N+1 … N+WIDTH. out_valid goes high after edge N+WIDTH, which is a latency of WIDTH cycles.
- With out_ready held high, out_valid is high for exactly 1 cycle and in_ready returns high 1 cycle after that.
- Throughput is 1 word per WIDTH+2 cycles.
- in_ready is registered (decoded from state). It is low from the cycle after accept until DONE exits.
- out_ready asserted before out_valid has no effect.
- Reset during SHIFT or DONE aborts the word: no out_valid pulse, state = IDLE, all outputs at reset values.

## Test plan
- WIDTH=4, in_data=0101 accepted at edge 0 -> out_valid high after edge 4 with out_sign=0, out_mag=0101, out_minneg=0. in_ready low on cycles 1–4, high again after the out handshake.
- in_data=1011 -> out_sign=1, out_mag=0101. in_data=1111 -> out_sign=1, out_mag=0001. in_data=0000 -> out_sign=0, out_mag=0000.
- in_data=1000 -> out_sign=1, out_mag=1000, out_minneg=1. in_data=0111 -> out_mag=0111, out_minneg=0.
- in_data=1110, out_ready held low for 5 cycles after out_valid -> out_sign=1 and out_mag=0010 stable throughout, in_ready=0. A concurrent in_valid with 0001 is ignored. One result only is delivered after out_ready rises.
- Assert rst_n low for 1 cycle after 2 SHIFT cycles of 1010 -> no out_valid, in_ready=1 after release. A following 0011 yields out_mag=0011 exactly 4 cycles after accept.
- Exhaustive sweep 0–15 with random out_ready stalls -> every result matches the reference model:
  - sign = bit 3
  - mag = sign ? (~x + 1) mod 16 : x
  - minneg only for 1000
  - no dropped or duplicated words

Source files
------------

// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude decoder (LSB first, copy-until-first-one-then-invert).
// One word in flight at a time, with valid/ready handshakes on both sides.
module twos_to_signmag_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_minneg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic             minneg_q, minneg_d;

  logic             bit_b;
  logic             res_bit;
  logic [WIDTH-1:0] asm_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      asm_q    <= '0;
      cnt_q    <= '0;
      seen_q   <= 1'b0;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      minneg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      asm_q    <= asm_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      minneg_q <= minneg_d;
    end
  end

  // Bits after the first 1 of a negative operand are inverted; earlier bits pass through.
  assign bit_b    = shift_q[0];
  assign res_bit  = bit_b ^ (sign_q & seen_q);
  assign asm_next = {res_bit, asm_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    asm_d    = asm_q;
    cnt_d    = cnt_q;
    seen_d   = seen_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    minneg_d = minneg_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in_data;
          sign_d  = in_data[WIDTH-1];
          seen_d  = 1'b0;
          cnt_d   = '0;
          asm_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = shift_q >> 1;
        asm_d   = asm_next;
        seen_d  = seen_q | (sign_q & bit_b);
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d  = DONE;
          mag_d    = asm_next;
          minneg_d = sign_q & (asm_next == MIN_NEG);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_sign   = sign_q;
  assign out_mag    = mag_q;
  assign out_minneg = minneg_q;

endmodule
